// File: rtl/room_renderer_pkg.sv
// Shared definitions for the room renderer: side indices, door FSM states,
// default colours and the aperture-width helper.
package room_renderer_pkg;

    localparam int unsigned SIDE_N = 0;
    localparam int unsigned SIDE_E = 1;
    localparam int unsigned SIDE_S = 2;
    localparam int unsigned SIDE_W = 3;

    typedef enum logic [1:0] {
        StClosed,
        StOpening,
        StOpen,
        StClosing
    } door_state_e;

    localparam logic [7:0] FLOOR_COLOR_DEF = 8'hB6;
    localparam logic [7:0] DOOR_COLOR_DEF  = 8'h64;

    // Bits needed to hold an aperture in 0..half.
    function automatic int unsigned ap_width(input int unsigned half);
        return (half == 0) ? 1 : $clog2(half + 1);
    endfunction

endpackage

// File: rtl/room_renderer_if.sv
// Pixel request/response bus between the VGA timing generator and the renderer.
//   CurrentX / CurrentY : pixel coordinate being requested (timing generator -> renderer)
//   mapData             : registered pixel colour, one clock later (renderer -> colour mux)
interface room_renderer_if #(
    parameter int unsigned X_W     = 10,
    parameter int unsigned Y_W     = 9,
    parameter int unsigned COLOR_W = 8
);
    logic [X_W-1:0]     CurrentX;
    logic [Y_W-1:0]     CurrentY;
    logic [COLOR_W-1:0] mapData;

    modport master (output CurrentX, output CurrentY, input mapData);
    modport slave  (input CurrentX, input CurrentY, output mapData);
endinterface

// File: rtl/room_renderer_door_anim.sv
// Sliding-door animator for one wall side: four-state FSM plus saturating
// aperture counter, both advancing only on frame_tick_i.
//   clk_vga, rst   : pixel clock, synchronous active-high reset
//   frame_tick_i   : one-cycle pulse per frame
//   req_i          : level request, 1 = open
//   aperture_o     : half-width of the opening in pixels (0..HALF)
//   open_o, busy_o : fully open / animating
module room_renderer_door_anim
    import room_renderer_pkg::*;
#(
    parameter int unsigned HALF      = 60,
    parameter int unsigned ANIM_STEP = 20,
    parameter bit          ENABLE    = 1'b1,
    parameter int unsigned AW        = ap_width(HALF)
) (
    input  logic          clk_vga,
    input  logic          rst,
    input  logic          frame_tick_i,
    input  logic          req_i,
    output logic [AW-1:0] aperture_o,
    output logic          open_o,
    output logic          busy_o
);

    localparam int unsigned STEP_SAT = (ANIM_STEP > HALF) ? HALF : ANIM_STEP;
    localparam logic [AW:0] HALF_C   = (AW + 1)'(HALF);
    localparam logic [AW:0] STEP_C   = (AW + 1)'(STEP_SAT);

    door_state_e   state_q, state_d;
    logic [AW-1:0] ap_q, ap_d;

    // One extra bit of headroom: both operands are <= HALF, so the sum never wraps.
    logic [AW:0] ap_ext, up, dn;
    assign ap_ext = {1'b0, ap_q};
    assign up     = (ap_ext + STEP_C > HALF_C) ? HALF_C : ap_ext + STEP_C;
    assign dn     = (ap_ext < STEP_C) ? '0 : ap_ext - STEP_C;

    // Next state follows from where the aperture lands, which covers the
    // CLOSED->OPEN shortcut and OPENING<->CLOSING reversals uniformly.
    always_comb begin
        state_d = state_q;
        ap_d    = ap_q;
        if (!ENABLE) begin
            state_d = StClosed;
            ap_d    = '0;
        end else if (frame_tick_i) begin
            if (req_i) begin
                ap_d    = up[AW-1:0];
                state_d = (up == HALF_C) ? StOpen : StOpening;
            end else begin
                ap_d    = dn[AW-1:0];
                state_d = (dn == '0) ? StClosed : StClosing;
            end
        end
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state_q <= StClosed;
            ap_q    <= '0;
        end else begin
            state_q <= state_d;
            ap_q    <= ap_d;
        end
    end

    assign aperture_o = ap_q;
    assign open_o     = (state_q == StOpen);
    assign busy_o     = (state_q == StOpening) || (state_q == StClosing);

endmodule

// File: rtl/room_renderer.sv
// Room-map pixel generator: four perimeter walls, an optional animated door
// centred on each wall, and the floor. One registered output, latency 1.
//   clk_vga, rst   : pixel clock, synchronous active-high reset
//   pix            : CurrentX/CurrentY in, mapData out (slave side)
//   wall           : runtime wall colour
//   frame_tick     : one pulse per frame, advances door animation
//   open_req       : per-side open request (bit0 N, 1 E, 2 S, 3 W)
//   door_open      : per-side fully open
//   door_busy      : per-side animating
module room_renderer
    import room_renderer_pkg::*;
#(
    parameter int unsigned        X_W         = 10,
    parameter int unsigned        Y_W         = 9,
    parameter int unsigned        COLOR_W     = 8,
    parameter int unsigned        H_ACTIVE    = 640,
    parameter int unsigned        V_ACTIVE    = 480,
    parameter int unsigned        WALL_T      = 40,
    parameter int unsigned        DOOR_W      = 120,
    parameter logic [3:0]         DOOR_MASK   = 4'b0001,
    parameter int unsigned        ANIM_STEP   = 20,
    parameter logic [COLOR_W-1:0] FLOOR_COLOR = FLOOR_COLOR_DEF,
    parameter logic [COLOR_W-1:0] DOOR_COLOR  = DOOR_COLOR_DEF
) (
    input  logic               clk_vga,
    input  logic               rst,
    room_renderer_if.slave     pix,
    input  logic [COLOR_W-1:0] wall,
    input  logic               frame_tick,
    input  logic [3:0]         open_req,
    output logic [3:0]         door_open,
    output logic [3:0]         door_busy
);

    localparam int unsigned HALF = DOOR_W / 2;
    localparam int unsigned AW   = ap_width(HALF);
    localparam int unsigned HC   = H_ACTIVE / 2;
    localparam int unsigned VC   = V_ACTIVE / 2;

    logic [AW-1:0] ap [4];

    for (genvar s = 0; s < 4; s++) begin : g_door
        room_renderer_door_anim #(
            .HALF      (HALF),
            .ANIM_STEP (ANIM_STEP),
            .ENABLE    (DOOR_MASK[s]),
            .AW        (AW)
        ) u_door (
            .clk_vga      (clk_vga),
            .rst          (rst),
            .frame_tick_i (frame_tick),
            .req_i        (open_req[s]),
            .aperture_o   (ap[s]),
            .open_o       (door_open[s]),
            .busy_o       (door_busy[s])
        );
    end

    logic [COLOR_W-1:0] map_q, map_d;
    int unsigned        x, y, p, c, a, side;
    logic               in_n, in_s, in_w, in_e;

    always_comb begin
        x    = 32'(pix.CurrentX);
        y    = 32'(pix.CurrentY);
        in_n = (y < WALL_T);
        in_s = (y >= V_ACTIVE - WALL_T);
        in_w = (x < WALL_T);
        in_e = (x >= H_ACTIVE - WALL_T);
        // Position along the wall and its centre, for whichever side this pixel is on.
        side = in_n ? SIDE_N : in_s ? SIDE_S : in_w ? SIDE_W : SIDE_E;
        p    = (in_n || in_s) ? x : y;
        c    = (in_n || in_s) ? HC : VC;
        a    = 32'(ap[side[1:0]]);
        map_d = FLOOR_COLOR;
        if (x >= H_ACTIVE || y >= V_ACTIVE) begin
            map_d = '0;
        end else if (in_n || in_s || in_w || in_e) begin
            map_d = wall;
            // Corners ((N|S) & (E|W)) never carry a door.
            if (!((in_n || in_s) && (in_w || in_e)) && DOOR_MASK[side[1:0]] &&
                (p + HALF >= c) && (p < c + HALF)) begin
                map_d = ((p + a >= c) && (p < c + a)) ? FLOOR_COLOR : DOOR_COLOR;
            end
        end
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            map_q <= '0;
        end else begin
            map_q <= map_d;
        end
    end

    assign pix.mapData = map_q;

endmodule

// File: tb/tb_room_renderer.sv
// Self-checking bench for room_renderer: pixel expectations go through a
// scoreboard queue and are popped one clock later when mapData is valid.
module tb_room_renderer;

    localparam logic [7:0] FLOOR = 8'hB6;
    localparam logic [7:0] DOOR  = 8'h64;
    localparam logic [7:0] WALL  = 8'h1C;

    logic       clk_vga = 1'b0;
    logic       rst;
    logic [7:0] wall;
    logic       frame_tick;
    logic [3:0] open_req;
    logic [3:0] door_open;
    logic [3:0] door_busy;

    room_renderer_if #(.X_W(10), .Y_W(9), .COLOR_W(8)) pix_if ();

    room_renderer dut (
        .clk_vga    (clk_vga),
        .rst        (rst),
        .pix        (pix_if.slave),
        .wall       (wall),
        .frame_tick (frame_tick),
        .open_req   (open_req),
        .door_open  (door_open),
        .door_busy  (door_busy)
    );

    always #5 clk_vga = ~clk_vga;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  sb_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Request one pixel; its colour is compared on the following cycle.
    task automatic px(input int x, input int y, input logic [7:0] e, input string tag);
        @(negedge clk_vga);
        pix_if.CurrentX = 10'(x);
        pix_if.CurrentY = 9'(y);
        sb_q.push_back(e);
        @(negedge clk_vga);
        check_val(tag, 32'(pix_if.mapData), 32'(sb_q.pop_front()));
    endtask

    task automatic tick();
        @(negedge clk_vga);
        frame_tick = 1'b1;
        @(negedge clk_vga);
        frame_tick = 1'b0;
    endtask

    task automatic status(input string tag, input logic [3:0] e_open, input logic [3:0] e_busy);
        check_val({tag, "_open"}, 32'(door_open), 32'(e_open));
        check_val({tag, "_busy"}, 32'(door_busy), 32'(e_busy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        wall            = WALL;
        frame_tick      = 1'b0;
        open_req        = 4'b0;
        pix_if.CurrentX = '0;
        pix_if.CurrentY = '0;
        repeat (3) @(negedge clk_vga);
        check_val("rst_map", 32'(pix_if.mapData), 32'h0);
        status("rst", 4'b0, 4'b0);
        rst = 1'b0;

        // Closed room
        px(300, 10, DOOR, "cl_door");
        px(100, 10, WALL, "cl_wall");
        px(10, 10, WALL, "cl_corner");
        @(negedge clk_vga);
        pix_if.CurrentX = 10'd320;
        pix_if.CurrentY = 9'd240;
        sb_q.push_back(FLOOR);
        #1 check_val("lat_hold", 32'(pix_if.mapData), 32'(WALL));
        @(negedge clk_vga);
        check_val("cl_floor", 32'(pix_if.mapData), 32'(sb_q.pop_front()));

        // Open north, a=20
        open_req = 4'b0001;
        tick();
        status("a20", 4'b0000, 4'b0001);
        px(300, 10, FLOOR, "a20_300");
        px(299, 10, DOOR, "a20_299");
        px(339, 10, FLOOR, "a20_339");
        px(340, 10, DOOR, "a20_340");
        repeat (5) @(negedge clk_vga);
        status("a20_hold", 4'b0000, 4'b0001);
        px(299, 10, DOOR, "a20_hold_299");

        // a=60, fully open
        tick();
        tick();
        status("a60", 4'b0001, 4'b0000);
        px(260, 10, FLOOR, "a60_260");
        px(379, 10, FLOOR, "a60_379");
        px(259, 10, WALL, "a60_259");
        px(380, 10, WALL, "a60_380");

        // Close from open: 40, 20, 0
        open_req = 4'b0000;
        tick();
        status("c40", 4'b0000, 4'b0001);
        px(280, 10, FLOOR, "c40_280");
        px(279, 10, DOOR, "c40_279");
        tick();
        px(300, 10, FLOOR, "c20_300");
        px(299, 10, DOOR, "c20_299");
        tick();
        status("c0", 4'b0000, 4'b0000);
        px(300, 10, DOOR, "c0_300");

        // Reverse mid-opening at a=40
        open_req = 4'b0001;
        tick();
        tick();
        px(280, 10, FLOOR, "o40_280");
        open_req = 4'b0000;
        tick();
        status("r20", 4'b0000, 4'b0001);
        px(300, 10, FLOOR, "r20_300");
        px(299, 10, DOOR, "r20_299");
        tick();
        status("r0", 4'b0000, 4'b0000);
        repeat (5) @(negedge clk_vga);
        status("r0_hold", 4'b0000, 4'b0000);
        px(300, 10, DOOR, "r0_300");

        // Blanking and masked side
        px(640, 0, 8'h00, "blank_x");
        px(0, 480, 8'h00, "blank_y");
        open_req = 4'b0010;
        tick();
        tick();
        status("mask_e", 4'b0000, 4'b0000);
        px(630, 240, WALL, "mask_e_pix");
        px(479, 470, WALL, "s_wall");

        // Reset mid-opening
        open_req = 4'b0001;
        tick();
        tick();
        status("pre_rst", 4'b0000, 4'b0001);
        px(300, 10, FLOOR, "pre_rst_300");
        @(negedge clk_vga);
        rst = 1'b1;
        @(negedge clk_vga);
        rst = 1'b0;
        check_val("rstmid_map", 32'(pix_if.mapData), 32'h0);
        status("rstmid", 4'b0000, 4'b0000);
        px(300, 10, DOOR, "rstmid_300");

        // Reset and tick together: reset wins
        @(negedge clk_vga);
        rst        = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk_vga);
        rst        = 1'b0;
        frame_tick = 1'b0;
        status("rst_tick", 4'b0000, 4'b0000);
        px(300, 10, DOOR, "rst_tick_300");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
